// File: rtl/alu8_seq_ctrl.sv
// Sequencer that feeds the team's 8-bit ALU from a small register file and writes results back.
// Optional z_flag/n_flag outputs are enabled by defining ALU_SEQ_FLAGS_EN.
module alu8_seq_ctrl #(
  parameter int NREG = 4,
  parameter int CNTW = 4,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_ld,
  input  logic [2:0]      req_op,
  input  logic [RW-1:0]   req_dst,
  input  logic [RW-1:0]   req_srca,
  input  logic [RW-1:0]   req_srcb,
  input  logic [7:0]      req_imm,
  input  logic [CNTW-1:0] req_cnt,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_s,
  input  logic [7:0]      alu_r,
  input  logic            alu_co,
  output logic            done,
  output logic [7:0]      res,
  output logic            co_flag
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic            z_flag,
  output logic            n_flag
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t          state;
  logic [7:0]      regs [NREG];
  logic            cap_ld;
  logic [2:0]      cap_op;
  logic [RW-1:0]   cap_dst;
  logic [RW-1:0]   cap_srca;
  logic [RW-1:0]   cap_srcb;
  logic [7:0]      cap_imm;
  logic [CNTW-1:0] cnt;
  logic [7:0]      result;
  logic            result_co;
  logic [7:0]      wb_data;

  assign req_ready = (state == IDLE);
  assign wb_data   = cap_ld ? cap_imm : result;

  // A chain step re-enters READ after WB, so the next read sees the value just written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cap_ld    <= 1'b0;
      cap_op    <= '0;
      cap_dst   <= '0;
      cap_srca  <= '0;
      cap_srcb  <= '0;
      cap_imm   <= '0;
      cnt       <= '0;
      result    <= '0;
      result_co <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      done      <= 1'b0;
      res       <= '0;
      co_flag   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      z_flag    <= 1'b0;
      n_flag    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_ld   <= req_ld;
            cap_op   <= req_op;
            cap_dst  <= req_dst;
            cap_srca <= req_srca;
            cap_srcb <= req_srcb;
            cap_imm  <= req_imm;
            cnt      <= req_ld ? '0 : req_cnt;
            state    <= req_ld ? WB : READ;
          end
        end
        READ: begin
          alu_a <= regs[cap_srca];
          alu_b <= regs[cap_srcb];
          alu_s <= cap_op;
          state <= EXEC;
        end
        EXEC: begin
          result    <= alu_r;
          result_co <= alu_co;
          state     <= WB;
        end
        WB: begin
          regs[cap_dst] <= wb_data;
          res           <= wb_data;
          co_flag       <= cap_ld ? 1'b0 : result_co;
`ifdef ALU_SEQ_FLAGS_EN
          z_flag        <= (wb_data == 8'h00);
          n_flag        <= wb_data[7];
`endif
          if (cnt != '0) begin
            cnt      <= cnt - 1'b1;
            cap_srca <= cap_dst;
            state    <= READ;
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu8_seq_ctrl.sv
// Scoreboard bench for alu8_seq_ctrl: a behavioural ALU answers the sequencer, and each
// request pushes its expected result and done cycle, popped when done pulses.
module tb_alu8_seq_ctrl;

  localparam int NREG = 4;
  localparam int CNTW = 4;
  localparam int RW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_ld;
  logic [2:0]      req_op;
  logic [RW-1:0]   req_dst;
  logic [RW-1:0]   req_srca;
  logic [RW-1:0]   req_srcb;
  logic [7:0]      req_imm;
  logic [CNTW-1:0] req_cnt;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [2:0]      alu_s;
  logic [7:0]      alu_r;
  logic            alu_co;
  logic            done;
  logic [7:0]      res;
  logic            co_flag;
`ifdef ALU_SEQ_FLAGS_EN
  logic            z_flag;
  logic            n_flag;
`endif

  typedef struct {
    logic [7:0] res;
    logic       co;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu8_seq_ctrl #(.NREG(NREG), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ld(req_ld), .req_op(req_op), .req_dst(req_dst),
    .req_srca(req_srca), .req_srcb(req_srcb),
    .req_imm(req_imm), .req_cnt(req_cnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_r(alu_r), .alu_co(alu_co),
    .done(done), .res(res), .co_flag(co_flag)
`ifdef ALU_SEQ_FLAGS_EN
    , .z_flag(z_flag), .n_flag(n_flag)
`endif
  );

  // Behavioural stand-in for the team ALU; only the add produces a carry.
  always_comb begin
    alu_r  = 8'h00;
    alu_co = 1'b0;
    case (alu_s)
      3'd0: {alu_co, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_r = alu_a - alu_b;
      3'd2: alu_r = alu_a + {alu_b[6:0], 1'b0};
      3'd3: alu_r = alu_a - {alu_b[6:0], 1'b0};
      3'd4: alu_r = alu_a ^ alu_b;
      3'd5: alu_r = (alu_a > alu_b) ? alu_a : alu_b;
      3'd6: alu_r = alu_a[7] ? (~alu_a + 8'd1) : alu_a;
      default: alu_r = alu_b;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("res", {24'h0, res}, {24'h0, mon_exp.res});
        checkOutput("co_flag", {31'h0, co_flag}, {31'h0, mon_exp.co});
        checkOutput("done_cycle", cyc, mon_exp.cyc);
      end
    end
  end

  task automatic applyStimulus(input logic ld, input logic [2:0] op, input logic [RW-1:0] dst,
                               input logic [RW-1:0] a, input logic [RW-1:0] b,
                               input logic [7:0] imm, input logic [CNTW-1:0] cnt,
                               input logic [7:0] exp_res, input logic exp_co);
    int guard = 0;
    int lat;
    @(negedge clk);
    req_ld = ld; req_op = op; req_dst = dst; req_srca = a; req_srcb = b;
    req_imm = imm; req_cnt = cnt; req_valid = 1'b1;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    lat = ld ? 1 : 3 * (int'(cnt) + 1);
    sb.push_back('{exp_res, exp_co, cyc + 1 + lat});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic loadReg(input logic [RW-1:0] dst, input logic [7:0] imm);
    applyStimulus(1'b1, 3'd0, dst, '0, '0, imm, '0, imm, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_pending", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_ld = 1'b0; req_op = '0; req_dst = '0;
    req_srca = '0; req_srcb = '0; req_imm = '0; req_cnt = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_res", {24'h0, res}, 0);
    checkOutput("rst_done", {31'h0, done}, 0);
    checkOutput("rst_alu_a", {24'h0, alu_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'h0, req_ready}, 1);

    // Basic add, overflow carry, then a load clearing the carry
    loadReg(2'd0, 8'h05);
    loadReg(2'd1, 8'h03);
    applyStimulus(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0, 8'h08, 1'b0);
    loadReg(2'd0, 8'hFF);
    loadReg(2'd1, 8'h01);
    applyStimulus(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0, 8'h00, 1'b1);
    loadReg(2'd3, 8'h10);
    drain();

    // Chained self-add: 2 -> 4 -> 8 -> 16, one done after 9 cycles
    loadReg(2'd0, 8'h02);
    applyStimulus(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 4'd2, 8'h10, 1'b0);
    drain();

    // Second request held while the first is busy; it reads the first result
    applyStimulus(1'b0, 3'd2, 2'd1, 2'd3, 2'd0, 8'h00, 4'd0, 8'h30, 1'b0);
    @(negedge clk);
    checkOutput("ready_busy", {31'h0, req_ready}, 0);
    applyStimulus(1'b0, 3'd7, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0, 8'h30, 1'b0);
    drain();

    // Remaining functions plus a load whose repeat count must be ignored
    loadReg(2'd0, 8'h80);
    applyStimulus(1'b0, 3'd6, 2'd3, 2'd0, 2'd0, 8'h00, 4'd0, 8'h80, 1'b0);
    loadReg(2'd1, 8'h05);
    loadReg(2'd2, 8'h09);
    applyStimulus(1'b0, 3'd5, 2'd3, 2'd1, 2'd2, 8'h00, 4'd0, 8'h09, 1'b0);
    loadReg(2'd0, 8'h10);
    loadReg(2'd1, 8'h03);
    applyStimulus(1'b0, 3'd3, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0, 8'h0A, 1'b0);
    applyStimulus(1'b0, 3'd1, 2'd3, 2'd1, 2'd0, 8'h00, 4'd0, 8'hF3, 1'b0);
    applyStimulus(1'b0, 3'd4, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0, 8'h13, 1'b0);
    applyStimulus(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h77, 4'd5, 8'h77, 1'b0);
    drain();

    // Asynchronous reset in the EXEC cycle of a cnt=3 chain
    loadReg(2'd0, 8'h01);
    drain();
    @(negedge clk);
    req_ld = 1'b0; req_op = 3'd0; req_dst = 2'd0; req_srca = 2'd0; req_srcb = 2'd0;
    req_cnt = 4'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_ready", {31'h0, req_ready}, 1);
    checkOutput("abort_res", {24'h0, res}, 0);
    checkOutput("abort_alu_a", {24'h0, alu_a}, 0);
    checkOutput("abort_alu_b", {24'h0, alu_b}, 0);
    checkOutput("abort_co_flag", {31'h0, co_flag}, 0);
    checkOutput("abort_done", {31'h0, done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    loadReg(2'd3, 8'h10);
    applyStimulus(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 4'd0, 8'h00, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu8_seq_ctrl.md
Name: alu8_seq_ctrl

Overview:
Sequencer that owns the team's 8-bit, 8-function ALU (select codes 0–7: add with carry, sub, A+2B, A−2B, xor, max, abs(A), pass B). It accepts operation requests over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU select and operand inputs, samples the combinational result, and writes it back. An optional repeat count chains the same op with the destination fed back as operand A.

Parameters:
NREG, 4, register-file depth (power of 2, ≥2); index width RW = log2(NREG)
CNTW, 4, width of repeat counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept (high only in IDLE)
req_ld  in  1  1 = load immediate, 0 = ALU op
req_op  in  3  ALU select code
req_dst  in  RW  destination register
req_srca  in  RW  operand A register
req_srcb  in  RW  operand B register
req_imm  in  8  immediate for load
req_cnt  in  CNTW  extra repeats (0 = execute once)
alu_a  out  8  ALU operand A (registered)
alu_b  out  8  ALU operand B (registered)
alu_s  out  3  ALU select (registered)
alu_r  in  8  ALU result
alu_co  in  1  ALU carry-out
done  out  1  one-cycle pulse when request fully retired
res  out  8  last written value, held until next write
co_flag  out  1  alu_co of last ALU writeback; cleared by loads

Behaviour:
- Reset (async, any state): state=IDLE; all registers, alu_a/alu_b/alu_s, res, co_flag, done, and the repeat counter = 0; req_ready=1 after reset release.
- States: IDLE, READ, EXEC, WB.
- IDLE: req_ready=1. On req_valid: capture all req_* fields. If req_ld → WB; else → READ. No request → stay.
- READ: alu_a<=reg[srca], alu_b<=reg[srcb], alu_s<=op; → EXEC.
- EXEC: sample alu_r/alu_co into result latch; → WB. The ALU is combinational, so one cycle suffices.
- WB: reg[dst]<=result (or imm for load); res<=same; co_flag<=alu_co (0 for load); done=1 only if counter==0.
  - counter>0: decrement, set srca:=dst, → READ (done stays 0).
  - counter==0: → IDLE.
- Latency from accept edge: load done asserted 1 cycle later; ALU op 3 cycles; chained op 3×(cnt+1) cycles. Exactly one done pulse per request.
- Hazards:
  - A chained READ sees the WB value, because the register write completes before READ samples.
  - srca==srcb==dst is legal.
- Width: all 8-bit, mod 256; carry only via alu_co (nonzero only for op 0, by the ALU's contract).
- req_ready is low in READ/EXEC/WB. req_valid while busy is ignored, and the requester must hold it. Capture happens only on the IDLE cycle with req_valid=1.
- req_cnt is ignored for loads.
- Reset mid-chain aborts: no done, register contents cleared.
- Registers are not readable externally except via res.

Optional Feature:
ALU_SEQ_FLAGS_EN:
- Defined: adds outputs z_flag (res==0) and n_flag (res[7]), both updated at each WB and reset to 0.
- Undefined: ports absent, no flag logic.

Test Plan:
- Load R0=0x05, R1=0x03; op0 dst=R2 a=R0 b=R1 cnt=0 → done exactly 3 cycles after accept, res=0x08, co_flag=0.
- R0=0xFF, R1=0x01, op0 → res=0x00, co_flag=1; following load R3=0x10 → co_flag=0, done 1 cycle after accept.
- R0=0x02, op0 dst=R0 a=R0 b=R0 cnt=2 → writes 0x04, 0x08, 0x10; single done at cycle 9; res=0x10.
- Request during EXEC with req_valid held → req_ready=0 until IDLE, then accepted the next cycle, result correct; no lost or duplicate done.
- R0=0x80, op6 → res=0x80; R1=0x05, R2=0x09, op5 a=R1 b=R2 → 0x09; op3 0x10−2×0x03 → 0x0A.
- rst pulsed asynchronously mid-EXEC of a cnt=3 chain → immediate IDLE, all outputs 0, no done; a fresh load after release works.
